// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges pipeline (A) and long-latency (B) writebacks
// onto the single regfile write port and tracks B-pending destinations.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        RF_clk,
  input  logic        RF_rst,
  input  logic        ena,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        stall,
  output logic        RF_W,
  output logic [4:0]  RdC,
  output logic [31:0] Rd
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic        wr_q, wr_d;
  logic [4:0]  rdc_q, rdc_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  scnt_q, scnt_d;

  logic a_win;
  logic b_acc;
  logic starve;
  logic set_ok;

  assign a_win   = ena & a_valid & (a_rd != 5'd0);
  assign b_ready = ena & b_valid & ~a_win;
  assign b_acc   = b_ready & (b_rd != 5'd0);
  assign starve  = (scnt_q == LIM);

  assign stall = ena & issue_valid
               & (busy_q[issue_rs] | busy_q[issue_rt]
                | busy_q[issue_rd] | starve);

  assign set_ok = ena & issue_valid & issue_long
                & ~stall & (issue_rd != 5'd0);

  always_comb begin
    wr_d  = 1'b0;
    rdc_d = rdc_q;
    rd_d  = rd_q;
    unique case (1'b1)
      a_win: begin
        wr_d  = 1'b1;
        rdc_d = a_rd;
        rd_d  = a_data;
      end
      b_acc: begin
        wr_d  = 1'b1;
        rdc_d = b_rd;
        rd_d  = b_data;
      end
      default: ;
    endcase
  end

  // a reissued long op to the same register outlives the old result
  always_comb begin
    busy_d = busy_q;
    if (b_acc)
      busy_d[b_rd] = 1'b0;
    if (set_ok)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    scnt_d = scnt_q;
    if (ena) begin
      if (b_valid & ~b_ready)
        scnt_d = starve ? scnt_q : scnt_q + 4'd1;
      else
        scnt_d = 4'd0;
    end
  end

  always_ff @(posedge RF_clk or posedge RF_rst) begin
    if (RF_rst) begin
      wr_q   <= 1'b0;
      rdc_q  <= 5'd0;
      rd_q   <= 32'd0;
      busy_q <= 32'd0;
      scnt_q <= 4'd0;
    end else begin
      wr_q   <= wr_d;
      rdc_q  <= rdc_d;
      rd_q   <= rd_d;
      busy_q <= busy_d;
      scnt_q <= scnt_d;
    end
  end

  assign RF_W = wr_q;
  assign RdC  = rdc_q;
  assign Rd   = rd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the arbiter.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 3;

  logic        RF_clk = 1'b0;
  logic        RF_rst = 1'b0;
  logic        ena = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_long = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  issue_rs = '0;
  logic [4:0]  issue_rt = '0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        stall;
  logic        RF_W;
  logic [4:0]  RdC;
  logic [31:0] Rd;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .RF_clk(RF_clk), .RF_rst(RF_rst), .ena(ena),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd), .issue_rs(issue_rs),
    .issue_rt(issue_rt),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data),
    .b_ready(b_ready), .stall(stall),
    .RF_W(RF_W), .RdC(RdC), .Rd(Rd)
  );

  always #5 RF_clk = ~RF_clk;

  int checks = 0;
  int failures = 0;

  // model state: which registers await B, how long B has waited,
  // and what the write port currently presents
  bit          m_busy [32];
  int          m_wait;
  bit          m_w;
  logic [4:0]  m_rdc;
  logic [31:0] m_rd;

  logic s_bready, s_stall;
  bit   bpend;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wait = 0;
    m_w = 1'b0;
    m_rdc = '0;
    m_rd = '0;
  endtask

  task automatic apply_reset();
    #1 RF_rst = 1'b1;
    #1;
    model_reset();
    chk("rst_RF_W", {31'd0, RF_W}, 32'd0);
    chk("rst_RdC", {27'd0, RdC}, 32'd0);
    chk("rst_Rd", Rd, 32'd0);
    @(negedge RF_clk);
    RF_rst = 1'b0;
    bpend = 1'b0;
  endtask

  task automatic idle();
    ena = 1'b1;
    issue_valid = 1'b0; issue_long = 1'b0;
    issue_rd = '0; issue_rs = '0; issue_rt = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  // one clock: check combinational outputs, clock the model, check regs
  task automatic step();
    bit e_aw, e_br, e_st, do_set;
    int nwait;
    #1;
    e_aw = ena && a_valid && (a_rd != 0);
    e_br = ena && b_valid && !e_aw;
    e_st = ena && issue_valid &&
           (m_busy[issue_rs] || m_busy[issue_rt] ||
            m_busy[issue_rd] || (m_wait == LIMIT));
    s_bready = b_ready;
    s_stall = stall;
    chk("b_ready", {31'd0, b_ready}, {31'd0, e_br});
    chk("stall", {31'd0, stall}, {31'd0, e_st});
    do_set = ena && issue_valid && issue_long && !e_st &&
             (issue_rd != 0);
    nwait = m_wait;
    if (ena) nwait = (b_valid && !e_br) ?
                     ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
    @(posedge RF_clk);
    if (e_aw) begin
      m_w = 1'b1; m_rdc = a_rd; m_rd = a_data;
    end else if (e_br && b_rd != 0) begin
      m_w = 1'b1; m_rdc = b_rd; m_rd = b_data;
    end else begin
      m_w = 1'b0;
    end
    if (e_br && b_rd != 0) m_busy[b_rd] = 1'b0;
    if (do_set) m_busy[issue_rd] = 1'b1;
    m_wait = nwait;
    #1;
    chk("RF_W", {31'd0, RF_W}, {31'd0, m_w});
    chk("RdC", {27'd0, RdC}, {27'd0, m_rdc});
    chk("Rd", Rd, m_rd);
  endtask

  initial begin
    int q[$];
    model_reset();
    bpend = 1'b0;
    #2;
    apply_reset();

    // reset cancels a pending write; A then writes r5
    idle();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hCAFE_0001;
    step();
    chk("pre_rst_W", {31'd0, RF_W}, 32'd1);
    apply_reset();
    idle();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234_5678;
    step();
    chk("a_r5_W", {31'd0, RF_W}, 32'd1);
    chk("a_r5_RdC", {27'd0, RdC}, 32'd5);
    chk("a_r5_Rd", Rd, 32'h1234_5678);

    // collision: A wins, B follows
    idle();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAAAA_0003;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hBBBB_0004;
    step();
    chk("col_bready0", {31'd0, s_bready}, 32'd0);
    chk("col_RdC3", {27'd0, RdC}, 32'd3);
    a_valid = 1'b0;
    step();
    chk("col_bready1", {31'd0, s_bready}, 32'd1);
    chk("col_RdC4", {27'd0, RdC}, 32'd4);
    chk("col_Rd4", Rd, 32'hBBBB_0004);

    // starvation
    apply_reset();
    idle();
    issue_valid = 1'b1;
    b_valid = 1'b1; b_rd = 5'd10; b_data = 32'h0000_BEEF;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_rd = 5'(i + 1); a_data = i;
      step();
      chk("starve_stall", {31'd0, s_stall}, (i == 3) ? 1 : 0);
    end
    a_valid = 1'b0;
    step();
    chk("starve_bready", {31'd0, s_bready}, 32'd1);
    chk("starve_RdC", {27'd0, RdC}, 32'd10);
    a_valid = 1'b1; a_rd = 5'd2; b_rd = 5'd11;
    step();
    chk("starve_cleared", {31'd0, s_stall}, 32'd0);

    // RAW hazard on r7
    apply_reset();
    idle();
    issue_valid = 1'b1; issue_long = 1'b1;
    issue_rd = 5'd7; issue_rs = 5'd1; issue_rt = 5'd2;
    step();
    chk("raw_issue", {31'd0, s_stall}, 32'd0);
    issue_long = 1'b0; issue_rd = 5'd8; issue_rs = 5'd7;
    step();
    chk("raw_stall", {31'd0, s_stall}, 32'd1);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h7777_0007;
    step();
    chk("raw_stall_acc", {31'd0, s_stall}, 32'd1);
    chk("raw_Rd", Rd, 32'h7777_0007);
    b_valid = 1'b0;
    step();
    chk("raw_release", {31'd0, s_stall}, 32'd0);

    // same-cycle set/clear on r9
    apply_reset();
    idle();
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
    step();
    chk("sc_bready", {31'd0, s_bready}, 32'd1);
    b_valid = 1'b0; issue_long = 1'b0;
    issue_rd = 5'd1; issue_rs = 5'd9;
    step();
    chk("sc_busy9", {31'd0, s_stall}, 32'd1);

    // r0 and ena
    apply_reset();
    idle();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hDEAD;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h4444;
    step();
    chk("r0_bready", {31'd0, s_bready}, 32'd1);
    chk("r0_RdC", {27'd0, RdC}, 32'd4);
    b_rd = 5'd0;
    step();
    chk("b_r0_W", {31'd0, RF_W}, 32'd0);
    ena = 1'b0; a_rd = 5'd5; b_rd = 5'd6; issue_valid = 1'b1;
    step();
    chk("ena0_bready", {31'd0, s_bready}, 32'd0);
    chk("ena0_W", {31'd0, RF_W}, 32'd0);
    chk("ena0_RdC", {27'd0, RdC}, 32'd4);

    // random traffic
    apply_reset();
    idle();
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) apply_reset();
      ena = ($urandom_range(0, 15) != 0);
      issue_valid = $urandom_range(0, 1);
      issue_long = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 7));
      issue_rs = 5'($urandom_range(0, 7));
      issue_rt = 5'($urandom_range(0, 7));
      a_valid = s_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      a_rd = 5'($urandom_range(0, 7));
      a_data = $urandom;
      if (!bpend && $urandom_range(0, 2) == 0) begin
        q.delete();
        for (int r = 1; r < 8; r++) if (m_busy[r]) q.push_back(r);
        bpend = 1'b1;
        b_data = $urandom;
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          b_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
        else
          b_rd = 5'($urandom_range(0, 7));
      end
      b_valid = bpend;
      step();
      if (bpend && ena && !(a_valid && a_rd != 0)) bpend = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. It merges two writeback sources into the single regfile write port: the single-cycle pipeline writeback (A) and a handshaked long-latency unit such as a multiplier, divider or memory (B). It drives the regfile `RF_W`/`RdC`/`Rd` inputs from registers, tracks destinations with writes outstanding from B, and raises a pipeline stall on hazards or when B is starved. It sits between the CPU's writeback stage and the regfile.

## Interface
- `STARVE_LIMIT`, 3: consecutive cycles B may be refused before a starvation stall is forced (1..15).
- `RF_clk` in 1: clock; internal state updates on posedge.
- `RF_rst` in 1: reset, asynchronous, active-high.
- `ena` in 1: global enable; same signal as the regfile's `RF_ena`.
- `issue_valid` in 1: instruction issuing this cycle.
- `issue_long` in 1: the issuing instruction's result comes back through B.
- `issue_rd` in 5: destination of the issuing instruction.
- `issue_rs`, `issue_rt` in 5 each: source registers of the issuing instruction.
- `a_valid` in 1: pipeline writeback request.
- `a_rd` in 5: destination address for A.
- `a_data` in 32: write data for A.
- `b_valid` in 1: long-latency result available.
- `b_rd` in 5: destination address for B.
- `b_data` in 32: write data for B.
- `b_ready` out 1: B accepted this cycle; combinational.
- `stall` out 1: pipeline must hold the issuing instruction; combinational.
- `RF_W` out 1: regfile write enable; registered.
- `RdC` out 5: regfile write address; registered.
- `Rd` out 32: regfile write data; registered.

## Operation
- **A grant:** A has fixed priority. `a_win = ena & a_valid & (a_rd != 0)`.
- **A write to r0:** dropped. It consumes no slot, and B may use the slot.
- **B accept:** `b_ready = ena & b_valid & ~a_win`. B holds `b_valid`, `b_rd` and `b_data` stable until `b_ready`.
- **B write to r0:** the handshake completes, `RF_W` stays 0, and no scoreboard change occurs.
- **Write port:** on each posedge with `ena`:
  - If `a_win`, capture A: `RF_W=1`, `RdC=a_rd`, `Rd=a_data`.
  - Else if B is accepted with `b_rd != 0`, capture B.
  - Otherwise `RF_W=0`, and `RdC`/`Rd` hold their previous values.
- **Scoreboard:** `busy[31:0]`, with `busy[0]` hard-wired to 0.
  - Set: on posedge when `ena & issue_valid & issue_long & ~stall & issue_rd != 0`, set `busy[issue_rd]`.
  - Clear: on posedge when `b_ready & b_rd != 0`, clear `busy[b_rd]`.
  - Set and clear of the same index in one cycle: set wins, because a new long op is reissued to that register.
- **Starvation counter `scnt`:**
  - Increments when `ena & b_valid & ~b_ready`.
  - Clears on `b_ready` or when `b_valid` is low.
  - Saturates at `STARVE_LIMIT`.
  - `starve = (scnt == STARVE_LIMIT)`.
- **Stall:** `stall = ena & issue_valid & (busy[issue_rs] | busy[issue_rt] | busy[issue_rd] | starve)`. The `busy[issue_rd]` term blocks write-after-write.
  - The pipeline deasserts `a_valid` in the cycle after `stall`, so B wins the following cycle.
- **`ena` low:** no grant, `b_ready=0`, `stall=0`. On the next posedge `RF_W` goes to 0. `busy` and `scnt` hold.
- **Reset values:** `RF_W=0`, `RdC=0`, `Rd=0`, `busy=0`, `scnt=0`. As a result `stall=0` and `b_ready` depends only on the inputs.

## Timing
- A request sampled at posedge k gives `RF_W`/`RdC`/`Rd` valid from just after posedge k through posedge k+1.
- The regfile commits the write at the negedge inside cycle k+1. Reads later in cycle k+1 see the new value.
- Write latency is 1 cycle plus a half cycle to regfile commit.
- `busy` clears at the same posedge that launches the B write. An issue that depends on that register is unstalled in cycle k+1 and reads the committed value after the negedge.
- B handshake: transfer occurs at the posedge where `b_valid & b_ready`. Maximum B wait is `STARVE_LIMIT + 2` cycles while A keeps writing.
- Reset mid-operation: a registered write still pending is cancelled (`RF_W` clears asynchronously), all busy bits are lost, and B must re-present after reset.

## Test plan
- **Reset:** assert `RF_rst` with `RF_W=1` pending -> `RF_W=0`, `RdC=0`, `Rd=0`, `busy=0` immediately. Release, then A writes r5 = 0x1234_5678 -> the regfile reads r5 = 0x1234_5678 one cycle later.
- **Collision:** `a_valid` and `b_valid` in the same cycle to r3 and r4 -> A is written first and `b_ready=0`. The next cycle (A idle) has `b_ready=1`, and r4 is written after that.
- **Starvation:** A is valid every cycle and B is waiting, with `STARVE_LIMIT=3` -> `stall` rises on B's 4th waiting cycle, A drops, B is written, `scnt=0`.
- **RAW hazard:** long issue to r7, then an issue reading r7 -> `stall=1` until the B write to r7 is accepted. The dependent instruction then reads B's data.
- **Same-cycle set/clear:** B clears r9 in the same cycle a new long op to r9 issues -> `busy[9]` remains 1.
- **r0 and `ena`:** A writes r0 -> `RF_W=0` and B is accepted the same cycle. With `ena=0` and both valid -> no `b_ready`, `RF_W=0`, counters frozen.
